// File: rtl/ifid_stage.sv
// ifid_stage: IF/ID pipeline register with load-use hazard detection, fetch PC enable and branch squash.
// Defining IFID_PERF_CNT_EN adds saturating StallCnt/FlushCnt performance counter ports.
module ifid_stage (
   input  logic        Clk,
   input  logic        Clr,
   input  logic [31:0] Inst,
   input  logic [31:0] PC,
   input  logic        Flush,
   input  logic        ExtStall,
   input  logic        EX_MemRead,
   input  logic        EX_Valid,
   input  logic [4:0]  EX_Rt,
   output logic        PCEn,
   output logic        Bubble,
   output logic [31:0] ID_Inst,
   output logic [31:0] ID_PC,
   output logic [31:0] ID_PC4,
   output logic        ID_Valid,
   output logic [5:0]  Op,
   output logic [4:0]  Rs,
   output logic [4:0]  Rt,
   output logic [4:0]  Rd,
   output logic [4:0]  Shamt,
   output logic [5:0]  Funct,
   output logic [15:0] Imm,
   output logic [1:0]  State
`ifdef IFID_PERF_CNT_EN
   ,
   output logic [31:0] StallCnt,
   output logic [31:0] FlushCnt
`endif
);

   localparam logic [1:0] ST_RUN  = 2'd0;
   localparam logic [1:0] ST_HOLD = 2'd1;
   localparam logic [1:0] ST_KILL = 2'd2;

   logic [1:0]  state_reg;
   logic [1:0]  state_next;
   logic [31:0] inst_reg;
   logic [31:0] pc_reg;
   logic        valid_reg;
   logic        load_use;
   logic        hold;

   // A load in EX writing $0 never creates a dependency, and a dead ID slot never stalls.
   assign load_use = valid_reg & EX_Valid & EX_MemRead & (EX_Rt != 5'd0) &
                     ((EX_Rt == inst_reg[25:21]) | (EX_Rt == inst_reg[20:16]));
   assign hold     = load_use | ExtStall;

   always_ff @(posedge Clk) begin
      if (Clr) begin
         state_reg <= ST_RUN;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = ST_RUN;
      if (Flush) begin
         state_next = ST_KILL;
      end else if (hold) begin
         state_next = ST_HOLD;
      end
   end

   always_comb begin
      PCEn   = ~Clr & (Flush | ~hold);
      Bubble = load_use & ~Flush;
      State  = state_reg;
   end

   // Flush beats hold: the squashed slot becomes a NOP but still tracks the fetch PC.
   always_ff @(posedge Clk) begin
      if (Clr) begin
         inst_reg  <= 32'd0;
         pc_reg    <= 32'd0;
         valid_reg <= 1'b0;
      end else if (Flush) begin
         inst_reg  <= 32'd0;
         pc_reg    <= PC;
         valid_reg <= 1'b0;
      end else if (!hold) begin
         inst_reg  <= Inst;
         pc_reg    <= PC;
         valid_reg <= 1'b1;
      end
   end

   assign ID_Inst  = inst_reg;
   assign ID_PC    = pc_reg;
   assign ID_PC4   = pc_reg + 32'd4;
   assign ID_Valid = valid_reg;
   assign Op       = inst_reg[31:26];
   assign Rs       = inst_reg[25:21];
   assign Rt       = inst_reg[20:16];
   assign Rd       = inst_reg[15:11];
   assign Shamt    = inst_reg[10:6];
   assign Funct    = inst_reg[5:0];
   assign Imm      = inst_reg[15:0];

`ifdef IFID_PERF_CNT_EN
   logic [31:0] stall_cnt_reg;
   logic [31:0] flush_cnt_reg;

   always_ff @(posedge Clk) begin
      if (Clr) begin
         stall_cnt_reg <= 32'd0;
         flush_cnt_reg <= 32'd0;
      end else begin
         if (Flush && (flush_cnt_reg != 32'hFFFF_FFFF)) begin
            flush_cnt_reg <= flush_cnt_reg + 32'd1;
         end
         if (!Flush && hold && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
         end
      end
   end

   assign StallCnt = stall_cnt_reg;
   assign FlushCnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_ifid_stage.sv
// Self-checking bench for ifid_stage: directed scenarios plus randomized traffic against a behavioural model.
// Counter checks are compiled in when IFID_PERF_CNT_EN is defined.
module tb_ifid_stage;

   logic        Clk = 1'b0;
   logic        Clr = 1'b1;
   logic [31:0] Inst = 32'd0;
   logic [31:0] PC = 32'd0;
   logic        Flush = 1'b0;
   logic        ExtStall = 1'b0;
   logic        EX_MemRead = 1'b0;
   logic        EX_Valid = 1'b0;
   logic [4:0]  EX_Rt = 5'd0;
   logic        PCEn, Bubble, ID_Valid;
   logic [31:0] ID_Inst, ID_PC, ID_PC4;
   logic [5:0]  Op, Funct;
   logic [4:0]  Rs, Rt, Rd, Shamt;
   logic [15:0] Imm;
   logic [1:0]  State;
`ifdef IFID_PERF_CNT_EN
   logic [31:0] StallCnt, FlushCnt;
`endif

   ifid_stage dut (
      .Clk(Clk), .Clr(Clr), .Inst(Inst), .PC(PC), .Flush(Flush), .ExtStall(ExtStall),
      .EX_MemRead(EX_MemRead), .EX_Valid(EX_Valid), .EX_Rt(EX_Rt),
      .PCEn(PCEn), .Bubble(Bubble), .ID_Inst(ID_Inst), .ID_PC(ID_PC), .ID_PC4(ID_PC4),
      .ID_Valid(ID_Valid), .Op(Op), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Shamt(Shamt),
      .Funct(Funct), .Imm(Imm), .State(State)
`ifdef IFID_PERF_CNT_EN
      , .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
   );

   always #5 Clk = ~Clk;

   int n_checks = 0;
   int n_fail = 0;
   int n_txn = 0;

   // Behavioural model of the ID slot, described in terms of pipeline actions.
   logic [31:0] m_inst = 32'd0;
   logic [31:0] m_pc = 32'd0;
   logic        m_valid = 1'b0;
   int          m_state = 0;
   longint      m_stall = 0;
   longint      m_flush = 0;

   function automatic logic m_load_use();
      int src1, src2;
      src1 = int'((m_inst >> 21) % 32);
      src2 = int'((m_inst >> 16) % 32);
      return m_valid && EX_Valid && EX_MemRead && (int'(EX_Rt) != 0) &&
             (int'(EX_Rt) == src1 || int'(EX_Rt) == src2);
   endfunction

   function automatic logic m_pcen();
      return !Clr && (Flush || !(m_load_use() || ExtStall));
   endfunction

   function automatic logic m_bubble();
      return m_load_use() && !Flush;
   endfunction

   // Advance the model by one edge from the current inputs, then step the DUT past that edge.
   task automatic tick();
      logic hold_now;
      string act;
      hold_now = m_load_use() || ExtStall;
      if (Clr) begin
         m_inst = 0; m_pc = 0; m_valid = 0; m_state = 0; m_stall = 0; m_flush = 0; act = "reset";
      end else if (Flush) begin
         m_inst = 0; m_valid = 0; m_pc = PC; m_state = 2; act = "kill";
         if (m_flush < 64'hFFFF_FFFF) m_flush++;
      end else if (hold_now) begin
         m_state = 1; act = "hold";
         if (m_stall < 64'hFFFF_FFFF) m_stall++;
      end else begin
         m_inst = Inst; m_pc = PC; m_valid = 1; m_state = 0; act = "load";
      end
      @(posedge Clk);
      #1;
      n_txn++;
      $display("txn %0d: %s inst=%08h pc=%08h -> id_inst=%08h id_pc=%08h state=%0d",
               n_txn, act, Inst, PC, ID_Inst, ID_PC, State);
   endtask

   task automatic test_reset();
      Clr = 1'b1; Inst = 32'h8C22_0004; PC = 32'd0;
      Flush = 0; ExtStall = 0; EX_MemRead = 0; EX_Valid = 0; EX_Rt = 0;
      tick();
      #3;
      n_checks++; if (PCEn !== 1'b0) begin n_fail++; $display("FAIL reset_pcen got %b want 0", PCEn); end
      n_checks++; if (Bubble !== 1'b0) begin n_fail++; $display("FAIL reset_bubble got %b want 0", Bubble); end
      tick();
      n_checks++; if (ID_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", ID_Valid); end
      n_checks++; if (ID_Inst !== 32'd0) begin n_fail++; $display("FAIL reset_inst got %08h want 0", ID_Inst); end
      n_checks++; if (ID_PC4 !== 32'd4) begin n_fail++; $display("FAIL reset_pc4 got %08h want 4", ID_PC4); end
      n_checks++; if (State !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", State); end
      n_checks++; if ({Op, Rs, Rt, Rd, Shamt, Funct} !== 32'd0) begin n_fail++; $display("FAIL reset_fields nonzero"); end
`ifdef IFID_PERF_CNT_EN
      n_checks++; if ({StallCnt, FlushCnt} !== 64'd0) begin n_fail++; $display("FAIL reset_cnt got %0d/%0d want 0/0", StallCnt, FlushCnt); end
`endif
      Clr = 1'b0;
      tick();
      n_checks++; if (ID_Inst !== 32'h8C22_0004) begin n_fail++; $display("FAIL first_load_inst got %08h want 8c220004", ID_Inst); end
      n_checks++; if (Rs !== 5'd1 || Rt !== 5'd2) begin n_fail++; $display("FAIL first_load_rs_rt got %0d/%0d want 1/2", Rs, Rt); end
      n_checks++; if (Imm !== 16'h0004) begin n_fail++; $display("FAIL first_load_imm got %04h want 0004", Imm); end
      n_checks++; if (ID_Valid !== 1'b1) begin n_fail++; $display("FAIL first_load_valid got %b want 1", ID_Valid); end
   endtask

   task automatic test_load_use();
      Inst = 32'h0043_2020; PC = 32'h10;
      tick();
      Inst = 32'h1111_1111; PC = 32'h14;
      EX_MemRead = 1; EX_Valid = 1; EX_Rt = 5'd2;
      #3;
      n_checks++; if (PCEn !== 1'b0) begin n_fail++; $display("FAIL lu_pcen got %b want 0", PCEn); end
      n_checks++; if (Bubble !== 1'b1) begin n_fail++; $display("FAIL lu_bubble got %b want 1", Bubble); end
      tick();
      n_checks++; if (ID_Inst !== 32'h0043_2020 || ID_PC !== 32'h10) begin n_fail++; $display("FAIL lu_hold got %08h/%08h want 00432020/00000010", ID_Inst, ID_PC); end
      n_checks++; if (State !== 2'd1) begin n_fail++; $display("FAIL lu_state got %0d want 1", State); end
      EX_MemRead = 0;
      #3;
      n_checks++; if (PCEn !== 1'b1 || Bubble !== 1'b0) begin n_fail++; $display("FAIL lu_release got pcen=%b bubble=%b want 1/0", PCEn, Bubble); end
      tick();
      n_checks++; if (ID_Inst !== 32'h1111_1111 || State !== 2'd0) begin n_fail++; $display("FAIL lu_advance got %08h state %0d want 11111111 state 0", ID_Inst, State); end
   endtask

   task automatic test_zero_guard();
      Inst = 32'h0003_2020; PC = 32'h20; EX_MemRead = 0;
      tick();
      EX_MemRead = 1; EX_Valid = 1; EX_Rt = 5'd0;
      #3;
      n_checks++; if (Bubble !== 1'b0 || PCEn !== 1'b1) begin n_fail++; $display("FAIL zero_guard got bubble=%b pcen=%b want 0/1", Bubble, PCEn); end
      EX_MemRead = 0; EX_Valid = 0;
   endtask

   task automatic test_flush_hold();
      Flush = 1; ExtStall = 1; PC = 32'h40;
      #3;
      n_checks++; if (PCEn !== 1'b1) begin n_fail++; $display("FAIL flush_pcen got %b want 1", PCEn); end
      tick();
      n_checks++; if (ID_Inst !== 32'd0 || ID_Valid !== 1'b0) begin n_fail++; $display("FAIL flush_nop got %08h valid %b want 0 valid 0", ID_Inst, ID_Valid); end
      n_checks++; if (ID_PC !== 32'h40) begin n_fail++; $display("FAIL flush_pc got %08h want 00000040", ID_PC); end
      n_checks++; if (State !== 2'd2) begin n_fail++; $display("FAIL flush_state got %0d want 2", State); end
      Flush = 0; ExtStall = 0;
   endtask

   task automatic test_wrap();
      PC = 32'hFFFF_FFFC; Inst = 32'h2001_0001;
      tick();
      n_checks++; if (ID_PC4 !== 32'd0) begin n_fail++; $display("FAIL wrap_pc4 got %08h want 00000000", ID_PC4); end
   endtask

   task automatic test_reset_mid_stall();
      ExtStall = 1;
      tick();
      Clr = 1;
      #3;
      n_checks++; if (PCEn !== 1'b0) begin n_fail++; $display("FAIL rst_stall_pcen got %b want 0", PCEn); end
      tick();
      n_checks++; if (State !== 2'd0 || ID_Valid !== 1'b0) begin n_fail++; $display("FAIL rst_stall_state got %0d valid %b want 0/0", State, ID_Valid); end
      Clr = 0; ExtStall = 0;
      #3;
      n_checks++; if (PCEn !== 1'b1) begin n_fail++; $display("FAIL rst_release_pcen got %b want 1", PCEn); end
   endtask

`ifdef IFID_PERF_CNT_EN
   task automatic test_counters();
      Clr = 1;
      tick();
      Clr = 0; ExtStall = 1;
      repeat (3) tick();
      ExtStall = 0; Flush = 1;
      repeat (2) tick();
      Flush = 0;
      n_checks++; if (StallCnt !== 32'd3 || FlushCnt !== 32'd2) begin n_fail++; $display("FAIL counters got %0d/%0d want 3/2", StallCnt, FlushCnt); end
      Clr = 1;
      tick();
      Clr = 0;
      n_checks++; if (StallCnt !== 32'd0 || FlushCnt !== 32'd0) begin n_fail++; $display("FAIL counters_clr got %0d/%0d want 0/0", StallCnt, FlushCnt); end
   endtask
`endif

   task automatic test_random();
      logic [31:0] w;
      for (int i = 0; i < 200; i++) begin
         w = $urandom;
         w[25:21] = 5'($urandom_range(0, 5));
         w[20:16] = 5'($urandom_range(0, 5));
         Inst = w;
         PC = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 9) == 0) PC = 32'hFFFF_FFFC;
         Clr = ($urandom_range(0, 29) == 0);
         Flush = ($urandom_range(0, 7) == 0);
         ExtStall = ($urandom_range(0, 4) == 0);
         EX_MemRead = $urandom_range(0, 1);
         EX_Valid = ($urandom_range(0, 3) != 0);
         EX_Rt = 5'($urandom_range(0, 5));
         #3;
         n_checks++; if (PCEn !== m_pcen()) begin n_fail++; $display("FAIL rnd_pcen[%0d] got %b want %b", i, PCEn, m_pcen()); end
         n_checks++; if (Bubble !== m_bubble()) begin n_fail++; $display("FAIL rnd_bubble[%0d] got %b want %b", i, Bubble, m_bubble()); end
         tick();
         n_checks++; if (ID_Inst !== m_inst || ID_PC !== m_pc || ID_Valid !== m_valid) begin
            n_fail++; $display("FAIL rnd_regs[%0d] got %08h/%08h/%b want %08h/%08h/%b", i, ID_Inst, ID_PC, ID_Valid, m_inst, m_pc, m_valid);
         end
         n_checks++; if (ID_PC4 !== m_pc + 32'd4) begin n_fail++; $display("FAIL rnd_pc4[%0d] got %08h want %08h", i, ID_PC4, m_pc + 32'd4); end
         n_checks++; if (int'(State) != m_state) begin n_fail++; $display("FAIL rnd_state[%0d] got %0d want %0d", i, State, m_state); end
         n_checks++; if (int'(Rd) != int'((m_inst >> 11) % 32) || int'(Funct) != int'(m_inst % 64) || int'(Op) != int'(m_inst >> 26)) begin
            n_fail++; $display("FAIL rnd_fields[%0d] got op=%0d rd=%0d funct=%0d for inst %08h", i, Op, Rd, Funct, m_inst);
         end
`ifdef IFID_PERF_CNT_EN
         n_checks++; if (longint'(StallCnt) != m_stall || longint'(FlushCnt) != m_flush) begin
            n_fail++; $display("FAIL rnd_cnt[%0d] got %0d/%0d want %0d/%0d", i, StallCnt, FlushCnt, m_stall, m_flush);
         end
`endif
      end
      Clr = 0; Flush = 0; ExtStall = 0; EX_MemRead = 0; EX_Valid = 0;
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_zero_guard();
      test_flush_hold();
      test_wrap();
      test_reset_mid_stall();
`ifdef IFID_PERF_CNT_EN
      test_counters();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
